covox_sd_dac: RTL and testbench



---
 rtl/covox_pkg.sv | 23 ++
 rtl/covox_sd_dac_sd_dac1.sv | 33 +++
 rtl/covox_sd_dac.sv | 176 +++++++++++++++++
 tb/tb_covox_sd_dac.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/covox_pkg.sv
// covox_pkg: shared types and constants for the Covox sigma-delta DAC.
//   covox_state_e  - controller state (IDLE / PLAY / DECAY)
//   MID_LEVEL      - mid-scale sample the output rests at when idle
//   DEF_*          - default timeout, decay divider and beeper mix level
//   sat8()         - clamp a 10-bit sum to 8 bits
package covox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DECAY = 2'd2
  } covox_state_e;

  localparam logic [7:0] MID_LEVEL        = 8'h80;
  localparam int         DEF_IDLE_TIMEOUT = 65535;
  localparam int         DEF_DECAY_DIV    = 256;
  localparam logic [7:0] DEF_BEEP_LVL     = 8'h40;

  function automatic logic [7:0] sat8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/covox_sd_dac_sd_dac1.sv
// sd_dac1: 8-bit first-order sigma-delta modulator.
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   level   - 8-bit input level, duty of dac_out is level/256
//   dac_out - registered 1-bit stream (carry out of the accumulator)
// The accumulator is only cleared by reset so level changes never glitch.
module sd_dac1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] level,
  output logic       dac_out
);

  logic [7:0] acc_q, acc_d;
  logic       dac_q, dac_d;

  always_comb begin
    {dac_d, acc_d} = {1'b0, acc_q} + {1'b0, level};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
      dac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dac_q <= dac_d;
    end
  end

  assign dac_out = dac_q;

endmodule

// File: rtl/covox_sd_dac.sv
// covox_sd_dac: Covox port writes -> 1-bit sigma-delta audio output.
//   cpu_clock - system clock (Z80 bus and decoder strobes synchronous)
//   reset     - asynchronous active-low reset
//   covox     - write strobe from port decoder, active high, >= 2 clocks
//   d         - Z80 data bus, stable while covox=1
//   beeper    - latched beeper bit (used only with COVOX_BEEPER_MIX_EN)
//   tapeout   - latched tapeout bit (used only with COVOX_BEEPER_MIX_EN)
//   dac_out   - sigma-delta bitstream to the RC filter
//   sample    - current sample after decay, never includes the mix
//   active    - 1 while in PLAY or DECAY
// Build option: define COVOX_BEEPER_MIX_EN to mix beeper/tapeout into the
// modulator level; undefined, those inputs are ignored.
//
// state    | meaning
// ST_IDLE  | no recent writes, sample parked at mid-scale
// ST_PLAY  | writes arriving, idle counter running
// ST_DECAY | timed out, sample stepping one LSB toward mid-scale
module covox_sd_dac
  import covox_pkg::*;
#(
  parameter int         IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int         DECAY_DIV    = DEF_DECAY_DIV,
  parameter logic [7:0] BEEP_LVL     = DEF_BEEP_LVL
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  output logic       dac_out,
  output logic [7:0] sample,
  output logic       active
);

  localparam logic [15:0] TMO_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]  DIV_LAST = 8'(DECAY_DIV - 1);

  // Strobe pipeline
  logic       cov_q, cov_d;
  logic       cov_p_q, cov_p_d;
  logic [7:0] din_q, din_d;
  logic       wr;

  always_comb begin
    cov_d   = covox;
    cov_p_d = cov_q;
    din_d   = d;
  end

  // One event per strobe regardless of its width
  assign wr = cov_q & ~cov_p_q;

  // Controller
  covox_state_e state_q, state_d;
  logic [7:0]   sample_q, sample_d;
  logic [15:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]   presc_q, presc_d;
  logic         active_q, active_d;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    idle_cnt_d = idle_cnt_q;
    presc_d    = presc_q;
    case (state_q)
      ST_IDLE: begin
        sample_d = MID_LEVEL;
        if (wr) begin
          state_d    = ST_PLAY;
          sample_d   = din_q;
          idle_cnt_d = 16'h0000;
          presc_d    = 8'h00;
        end
      end
      ST_PLAY: begin
        // A write always takes priority over the timeout
        if (wr) begin
          sample_d   = din_q;
          idle_cnt_d = 16'h0000;
          presc_d    = 8'h00;
        end else if (idle_cnt_q == TMO_LAST) begin
          state_d = ST_DECAY;
          presc_d = 8'h00;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      ST_DECAY: begin
        if (wr) begin
          state_d    = ST_PLAY;
          sample_d   = din_q;
          idle_cnt_d = 16'h0000;
          presc_d    = 8'h00;
        end else if (sample_q == MID_LEVEL) begin
          state_d = ST_IDLE;
        end else if (presc_q == DIV_LAST) begin
          presc_d  = 8'h00;
          sample_d = (sample_q > MID_LEVEL) ? sample_q - 8'd1 : sample_q + 8'd1;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sample_d = MID_LEVEL;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      cov_q      <= 1'b0;
      cov_p_q    <= 1'b0;
      din_q      <= 8'h00;
      state_q    <= ST_IDLE;
      sample_q   <= MID_LEVEL;
      idle_cnt_q <= 16'h0000;
      presc_q    <= 8'h00;
      active_q   <= 1'b0;
    end else begin
      cov_q      <= cov_d;
      cov_p_q    <= cov_p_d;
      din_q      <= din_d;
      state_q    <= state_d;
      sample_q   <= sample_d;
      idle_cnt_q <= idle_cnt_d;
      presc_q    <= presc_d;
      active_q   <= active_d;
    end
  end

  // Modulator level
  logic [7:0] level;

`ifdef COVOX_BEEPER_MIX_EN
  logic       beep_q, beep_d;
  logic       tape_q, tape_d;
  logic [9:0] mix_sum;

  always_comb begin
    beep_d  = beeper;
    tape_d  = tapeout;
    mix_sum = {2'b00, sample_q}
            + (beep_q ? {2'b00, BEEP_LVL} : 10'd0)
            + (tape_q ? {4'b0000, BEEP_LVL[7:2]} : 10'd0);
    level   = sat8(mix_sum);
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      beep_q <= 1'b0;
      tape_q <= 1'b0;
    end else begin
      beep_q <= beep_d;
      tape_q <= tape_d;
    end
  end
`else
  logic unused_mix;
  assign unused_mix = ^{beeper, tapeout, BEEP_LVL};
  assign level      = sample_q;
`endif

  sd_dac1 u_sd_dac1 (
    .clk     (cpu_clock),
    .rst_n   (reset),
    .level   (level),
    .dac_out (dac_out)
  );

  assign sample = sample_q;
  assign active = active_q;

endmodule

// File: tb/tb_covox_sd_dac.sv
// tb_covox_sd_dac: bench for covox_sd_dac.
// dut_a uses default timing (duty-cycle windows), dut_b uses a short
// timeout/divider (16/4) to exercise timeout, decay and write priority.
module tb_covox_sd_dac;

  logic       cpu_clock = 1'b0;
  logic       reset     = 1'b0;
  logic       covox_a   = 1'b0;
  logic       covox_b   = 1'b0;
  logic [7:0] d         = 8'h00;
  logic       beeper    = 1'b0;
  logic       tapeout   = 1'b0;
  logic       dac_a, dac_b, active_a, active_b;
  logic [7:0] sample_a, sample_b;

  always #5 cpu_clock = ~cpu_clock;

  covox_sd_dac dut_a (
    .cpu_clock (cpu_clock), .reset (reset), .covox (covox_a), .d (d),
    .beeper (beeper), .tapeout (tapeout),
    .dac_out (dac_a), .sample (sample_a), .active (active_a)
  );

  covox_sd_dac #(.IDLE_TIMEOUT(16), .DECAY_DIV(4)) dut_b (
    .cpu_clock (cpu_clock), .reset (reset), .covox (covox_b), .d (d),
    .beeper (beeper), .tapeout (tapeout),
    .dac_out (dac_b), .sample (sample_b), .active (active_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Timed scoreboard: {edge count at which to check, signal, value}
  typedef struct { int at; int sel; int val; } exp_t;
  exp_t sb[$];
  int   win_q[$];
  int   edge_cnt = 0;

  always @(posedge cpu_clock) edge_cnt <= edge_cnt + 1;

  function automatic void sb_push(input int at, input int sel, input int val);
    exp_t e;
    int   i;
    e.at = at; e.sel = sel; e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endfunction

  function automatic int observe(input int sel);
    case (sel)
      0:       return int'(sample_a);
      1:       return int'(active_a);
      2:       return int'(sample_b);
      3:       return int'(active_b);
      default: return -1;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "sample_a";
      1:       return "active_a";
      2:       return "sample_b";
      3:       return "active_b";
      default: return "unknown";
    endcase
  endfunction

  always @(negedge cpu_clock) begin : sb_chk
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
      e = sb.pop_front();
      check($sformatf("%s@%0d", sel_name(e.sel), e.at), observe(e.sel), e.val);
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge cpu_clock);
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Called at a negedge; strobe rise is sampled at the next posedge (N).
  task automatic write(input bit to_b, input logic [7:0] val, input int width, input int old);
    int e0;
    int ss;
    e0 = edge_cnt;
    ss = to_b ? 2 : 0;
    d  = val;
    if (to_b) covox_b = 1'b1; else covox_a = 1'b1;
    sb_push(e0 + 1, ss, old);
    sb_push(e0 + 2, ss, int'(val));
    sb_push(e0 + 2, ss + 1, 1);
    repeat (width) @(negedge cpu_clock);
    covox_a = 1'b0;
    covox_b = 1'b0;
  endtask

  task automatic measure(input string tag);
    int ones;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge cpu_clock);
      ones += int'(dac_a);
    end
    if (win_q.size() == 0) check({tag, "_noexp"}, ones, -1);
    else check(tag, ones, win_q.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e0, e1;
    repeat (3) @(negedge cpu_clock);
    check("rst_sample_a", int'(sample_a), 'h80);
    check("rst_dac_a",    int'(dac_a),    0);
    check("rst_active_a", int'(active_a), 0);
    check("rst_sample_b", int'(sample_b), 'h80);
    check("rst_dac_b",    int'(dac_b),    0);
    reset = 1'b1;

    repeat (2) @(negedge cpu_clock);
    win_q.push_back(128);
    measure("duty_idle");

    write(1'b0, 8'h40, 3, 'h80);
    win_q.push_back(64);
    repeat (4) @(negedge cpu_clock);
    drain(20);
    measure("duty_40");

`ifdef COVOX_BEEPER_MIX_EN
    write(1'b0, 8'hF0, 2, 'h40);
    beeper = 1'b1;
    repeat (4) @(negedge cpu_clock);
    win_q.push_back(255);
    measure("mix_f0_beep");
    check("mix_f0_sample", int'(sample_a), 'hF0);
    write(1'b0, 8'h20, 2, 'hF0);
    tapeout = 1'b1;
    repeat (4) @(negedge cpu_clock);
    win_q.push_back('h70);
    measure("mix_20_beep_tape");
    check("mix_20_sample", int'(sample_a), 'h20);
    beeper  = 1'b0;
    tapeout = 1'b0;
    write(1'b0, 8'h40, 2, 'h20);
    drain(10);
`else
    beeper  = 1'b1;
    tapeout = 1'b1;
    repeat (4) @(negedge cpu_clock);
    win_q.push_back(64);
    measure("beep_ignored");
    beeper  = 1'b0;
    tapeout = 1'b0;
`endif

    // Asynchronous reset mid-stream
    @(negedge cpu_clock);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sample", int'(sample_a), 'h80);
    check("async_rst_dac",    int'(dac_a),    0);
    check("async_rst_active", int'(active_a), 0);
    @(negedge cpu_clock);
    reset = 1'b1;
    repeat (2) @(negedge cpu_clock);
    win_q.push_back(128);
    measure("duty_after_rst");

    // Extremes
    write(1'b0, 8'h00, 2, 'h80);
    repeat (4) @(negedge cpu_clock);
    win_q.push_back(0);
    measure("duty_00");
    write(1'b0, 8'hFF, 2, 'h00);
    repeat (4) @(negedge cpu_clock);
    win_q.push_back(255);
    measure("duty_ff");

    // Wide strobe (single capture), timeout and decay to mid-scale
    e0 = edge_cnt;
    sb_push(e0 + 17, 3, 1);
    sb_push(e0 + 17, 2, 'h83);
    sb_push(e0 + 21, 2, 'h83);
    sb_push(e0 + 22, 2, 'h82);
    sb_push(e0 + 26, 2, 'h81);
    sb_push(e0 + 29, 2, 'h81);
    sb_push(e0 + 30, 2, 'h80);
    sb_push(e0 + 30, 3, 1);
    sb_push(e0 + 31, 3, 0);
    write(1'b1, 8'h83, 10, 'h80);
    drain(60);

    // Write during decay restarts the idle counter
    e0 = edge_cnt;
    sb_push(e0 + 22, 2, 'h82);
    write(1'b1, 8'h83, 2, 'h80);
    while (edge_cnt < e0 + 23) @(negedge cpu_clock);
    e1 = edge_cnt;
    sb_push(e1 + 21, 2, 'h10);
    sb_push(e1 + 22, 2, 'h11);
    write(1'b1, 8'h10, 2, 'h82);
    drain(40);

    // Write landing on the exact timeout cycle keeps PLAY
    e0 = edge_cnt;
    write(1'b1, 8'h90, 2, 'h11);
    while (edge_cnt < e0 + 16) @(negedge cpu_clock);
    e1 = edge_cnt;
    sb_push(e1 + 21, 2, 'h95);
    sb_push(e1 + 22, 2, 'h94);
    write(1'b1, 8'h95, 2, 'h90);
    drain(40);

    drain(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
